// File: rtl/legv8_seq_pkg.sv
// Shared types and defaults for the LEGv8 multi-cycle sequencer.
package legv8_seq_pkg;

  localparam int unsigned OPCODE_W            = 11;
  localparam int unsigned WAIT_W              = 8;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 11'h7FF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_FAULT     = 3'd7
  } seq_state_t;

  // Busy covers every state that belongs to an instruction in flight.
  function automatic logic is_busy_state(input seq_state_t s);
    return !(s inside {S_IDLE, S_HALTED, S_FAULT});
  endfunction

endpackage

// File: rtl/cycle_sequencer.sv
// Multi-cycle stage-enable sequencer: fetch/decode/execute/memory/writeback
// with run/step/halt control, memory-ready timeout and event counters.
module cycle_sequencer
  import legv8_seq_pkg::*;
#(
  parameter int unsigned          CNT_W       = 32,
  parameter int unsigned          MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                mem_ready,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              resume_halt_q, resume_halt_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic              fetch_en_q, fetch_en_d;
  logic              decode_en_q, decode_en_d;
  logic              exec_en_q, exec_en_d;
  logic              mem_en_q, mem_en_d;
  logic              wb_en_q, wb_en_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      resume_halt_q <= 1'b0;
      instr_q       <= '0;
      cycle_q       <= '0;
      fetch_en_q    <= 1'b0;
      decode_en_q   <= 1'b0;
      exec_en_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      wb_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      resume_halt_q <= resume_halt_d;
      instr_q       <= instr_d;
      cycle_q       <= cycle_d;
      fetch_en_q    <= fetch_en_d;
      decode_en_q   <= decode_en_d;
      exec_en_q     <= exec_en_d;
      mem_en_q      <= mem_en_d;
      wb_en_q       <= wb_en_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state, counters, and registered outputs derived from the next state.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    resume_halt_d = resume_halt_q;
    instr_d       = instr_q;
    cycle_d       = busy_q ? cycle_q + CNT_W'(1) : cycle_q;

    unique case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        wait_d  = '0;
        state_d = (mem_read || mem_write) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        wait_d = wait_q + WAIT_W'(1);
        if (mem_ready)              state_d = S_WRITEBACK;
        else if (wait_q == WAIT_LAST) state_d = S_FAULT;
      end
      S_WRITEBACK: begin
        instr_d       = instr_q + CNT_W'(1);
        resume_halt_d = 1'b0;
        // An instruction stepped out of HALTED returns there afterwards.
        if (opcode == HALT_OPCODE)  state_d = S_HALTED;
        else if (halt_req)          state_d = S_HALTED;
        else if (resume_halt_q)     state_d = S_HALTED;
        else if (run)               state_d = S_FETCH;
        else                        state_d = S_IDLE;
      end
      S_HALTED: begin
        if (step) begin
          state_d       = S_FETCH;
          resume_halt_d = 1'b1;
        end
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase

    fetch_en_d  = (state_d == S_FETCH);
    decode_en_d = (state_d == S_DECODE);
    exec_en_d   = (state_d == S_EXECUTE);
    mem_en_d    = (state_d == S_MEMORY);
    wb_en_d     = (state_d == S_WRITEBACK);
    busy_d      = is_busy_state(state_d);
    halted_d    = (state_d == S_HALTED);
    fault_d     = (state_d == S_FAULT);
  end

  assign fetch_en    = fetch_en_q;
  assign decode_en   = decode_en_q;
  assign exec_en     = exec_en_q;
  assign mem_en      = mem_en_q;
  assign wb_en       = wb_en_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign instr_count = instr_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed self-checking bench for cycle_sequencer.
module tb_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, step, halt_req;
  logic [10:0] opcode;
  logic        mem_read, mem_write, mem_ready;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        busy, halted, fault;
  logic [31:0] instr_count, cycle_count;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [4:0] EN_F = 5'b10000;
  localparam logic [4:0] EN_D = 5'b01000;
  localparam logic [4:0] EN_E = 5'b00100;
  localparam logic [4:0] EN_M = 5'b00010;
  localparam logic [4:0] EN_W = 5'b00001;
  localparam logic [4:0] EN_0 = 5'b00000;

  cycle_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .opcode      (opcode),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_ready   (mem_ready),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .mem_en      (mem_en),
    .wb_en       (wb_en),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] en_vec();
    return {fetch_en, decode_en, exec_en, mem_en, wb_en};
  endfunction

  function automatic logic [4:0] alu_phase(input int c);
    case ((c - 1) % 4)
      0:       return EN_F;
      1:       return EN_D;
      2:       return EN_E;
      default: return EN_W;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_en(input string tag, input logic [4:0] exp);
    tick();
    check(tag, 32'(en_vec()), 32'(exp));
  endtask

  task automatic check_status(input string tag, input logic b, input logic h, input logic f,
                              input logic [31:0] ic, input logic [31:0] cc);
    check({tag, "_en"},     32'(en_vec()), 32'(EN_0));
    check({tag, "_busy"},   32'(busy),     32'(b));
    check({tag, "_halted"}, 32'(halted),   32'(h));
    check({tag, "_fault"},  32'(fault),    32'(f));
    check({tag, "_instr"},  instr_count,   ic);
    check({tag, "_cycle"},  cycle_count,   cc);
  endtask

  // Async reset pulse inside the current cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_status(tag, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    opcode = 11'h000; mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
    #11;
    check_status("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 reset = 1'b0;

    // Three back-to-back ALU instructions
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick_en($sformatf("alu_c%0d", c), alu_phase(c));
      if (c == 1) check("alu_busy", 32'(busy), 32'd1);
      if (c == 9) run = 1'b0;
    end
    tick();
    check_status("alu_done", 1'b0, 1'b0, 1'b0, 32'd3, 32'd12);

    // LDUR with mem_ready on the third MEMORY cycle
    mem_read = 1'b1; run = 1'b1;
    tick_en("ld_f", EN_F); run = 1'b0;
    tick_en("ld_d", EN_D);
    tick_en("ld_e", EN_E);
    tick_en("ld_m1", EN_M);
    tick_en("ld_m2", EN_M);
    tick_en("ld_m3", EN_M); mem_ready = 1'b1;
    tick_en("ld_w", EN_W); mem_ready = 1'b0; mem_read = 1'b0;
    tick();
    check_status("ld_done", 1'b0, 1'b0, 1'b0, 32'd4, 32'd19);

    // mem_ready already high on the first MEMORY cycle
    mem_read = 1'b1; mem_ready = 1'b1; run = 1'b1;
    tick_en("ldf_f", EN_F); run = 1'b0;
    tick_en("ldf_d", EN_D);
    tick_en("ldf_e", EN_E);
    tick_en("ldf_m", EN_M);
    tick_en("ldf_w", EN_W); mem_read = 1'b0; mem_ready = 1'b0;
    tick();
    check_status("ldf_done", 1'b0, 1'b0, 1'b0, 32'd5, 32'd24);

    // Single step from IDLE; a second step mid-instruction is ignored
    step = 1'b1;
    tick_en("st_f", EN_F); step = 1'b0;
    tick_en("st_d", EN_D); step = 1'b1;
    tick_en("st_e", EN_E); step = 1'b0;
    tick_en("st_w", EN_W);
    tick();
    check_status("st_done", 1'b0, 1'b0, 1'b0, 32'd6, 32'd28);
    tick();
    check_status("st_idle", 1'b0, 1'b0, 1'b0, 32'd6, 32'd28);

    // halt_req during EXECUTE of instruction 2
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick_en($sformatf("hr_c%0d", c), alu_phase(c));
      if (c == 7) halt_req = 1'b1;
    end
    tick();
    check_status("hr_halt", 1'b0, 1'b1, 1'b0, 32'd8, 32'd36);
    tick(); tick();
    check_status("hr_stay", 1'b0, 1'b1, 1'b0, 32'd8, 32'd36);
    halt_req = 1'b0;
    tick();
    check_status("hr_run_only", 1'b0, 1'b1, 1'b0, 32'd8, 32'd36);
    run = 1'b0; step = 1'b1;
    tick_en("hs_f", EN_F); step = 1'b0;
    tick_en("hs_d", EN_D);
    tick_en("hs_e", EN_E);
    tick_en("hs_w", EN_W);
    tick();
    check_status("hs_back", 1'b0, 1'b1, 1'b0, 32'd9, 32'd40);

    // HALT opcode stops the sequencer even with run held
    do_reset("rst1");
    run = 1'b1; opcode = 11'h7FF;
    tick_en("ho_f", EN_F);
    tick_en("ho_d", EN_D);
    tick_en("ho_e", EN_E);
    tick_en("ho_w", EN_W);
    tick();
    check_status("ho_halt", 1'b0, 1'b1, 1'b0, 32'd1, 32'd4);
    tick();
    check_status("ho_stay", 1'b0, 1'b1, 1'b0, 32'd1, 32'd4);
    run = 1'b0; opcode = 11'h000;

    // Memory timeout with mem_ready held low
    do_reset("rst2");
    mem_write = 1'b1; run = 1'b1;
    tick_en("to_f", EN_F); run = 1'b0;
    tick_en("to_d", EN_D);
    tick_en("to_e", EN_E);
    for (int i = 1; i <= 15; i++) tick_en($sformatf("to_m%0d", i), EN_M);
    tick();
    check_status("to_fault", 1'b0, 1'b0, 1'b1, 32'd0, 32'd18);
    run = 1'b1; step = 1'b1;
    tick(); tick();
    check_status("to_sticky", 1'b0, 1'b0, 1'b1, 32'd0, 32'd18);
    run = 1'b0; step = 1'b0; mem_write = 1'b0;

    // Reset asserted in the middle of a MEMORY phase
    do_reset("rst3");
    mem_read = 1'b1; run = 1'b1;
    tick_en("rm_f", EN_F); run = 1'b0;
    tick_en("rm_d", EN_D);
    tick_en("rm_e", EN_E);
    tick_en("rm_m", EN_M);
    do_reset("rm_reset");
    mem_read = 1'b0;
    tick();
    check_status("rm_idle", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Single-clock multi-cycle controller for the non-pipelined LEGv8 datapath. It replaces the oscillator-plus-delay phase clocks with one-cycle stage enables, sequenced as fetch -> decode -> execute -> memory -> writeback. It adds run/step/halt debug control, a memory-ready wait with timeout, and instruction/cycle counters. It sits between the top-level harness and the Fetch/Decode/Execute/Memory/Writeback stages.

Parameters:
CNT_W, 32, width of instr_count and cycle_count
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready before fault (1..255)
HALT_OPCODE, 11'h7FF, opcode that stops the sequencer after its writeback

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
run  in  1  level; 1 = free-run instructions back-to-back
step  in  1  single-cycle pulse; executes exactly one instruction when not running
halt_req  in  1  level; stop at the next instruction boundary
opcode  in  11  decoded opcode of the current instruction, valid from DECODE onward
mem_read  in  1  control from Decode
mem_write  in  1  control from Decode
mem_ready  in  1  data memory has completed the access
fetch_en  out  1  PC register and instruction-memory enable
decode_en  out  1  register-file read and control-decode enable
exec_en  out  1  ALU, flag-register, and branch-target enable
mem_en  out  1  data-memory access strobe; held for the whole access
wb_en  out  1  register-file write and PC update enable
busy  out  1  1 whenever state is not IDLE, HALTED, or FAULT
halted  out  1  1 in HALTED
fault  out  1  1 in FAULT (memory timeout)
instr_count  out  CNT_W  retired instructions
cycle_count  out  CNT_W  cycles spent while busy

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all enables = 0; busy, halted, fault = 0; both counters = 0; wait counter = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED, FAULT.
- Enables are registered and one-hot: fetch_en=1 only in FETCH, decode_en only in DECODE, exec_en only in EXECUTE, mem_en only in MEMORY, wb_en only in WRITEBACK.
- IDLE -> FETCH when run=1 or step=1; otherwise stay in IDLE.
- FETCH -> DECODE -> EXECUTE unconditionally, one cycle each.
- EXECUTE -> MEMORY if mem_read|mem_write; otherwise -> WRITEBACK, skipping the memory phase.
- MEMORY: stay while mem_ready=0. The wait counter increments each cycle. Go to WRITEBACK on the cycle mem_ready=1 is sampled. Go to FAULT when the counter reaches MEM_TIMEOUT with mem_ready still 0. mem_ready=1 on the first MEMORY cycle gives a 1-cycle memory phase.
- Latency: 4 cycles per non-memory instruction; 5 + wait cycles per memory instruction.
- WRITEBACK: instr_count increments by 1 (wraps at 2^CNT_W-1 -> 0). Exit priority, highest first:
  1. opcode == HALT_OPCODE -> HALTED
  2. halt_req=1 -> HALTED
  3. run=1 -> FETCH
  4. otherwise -> IDLE
- step is ignored while busy. A step pulse arriving together with run=1 in IDLE behaves as run.
- HALTED: leaves only via reset, or via step=1 (executes one instruction then returns to HALTED). run does not leave HALTED unless halt_req=0 and step=1.
- FAULT: sticky, exits only via reset; all enables stay 0.
- cycle_count increments every cycle busy=1, wrapping at the maximum value.
- halt_req is never sampled mid-instruction; an instruction already in flight always completes.
- Reset mid-MEMORY drops mem_en immediately (asynchronously).

Decomposition:
- Shared package legv8_seq_pkg holds:
  - seq_state_t enum (3-bit encoding)
  - OPCODE_W = 11
  - HALT_OPCODE default
  - MEM_TIMEOUT default
- No sub-module: the wait counter and the two event counters are inline registers.

Test Plan:
- Reset then run=1, 3 ALU instructions, no memory -> fetch_en pulses at cycles 1, 5, 9; wb_en at 4, 8, 12; instr_count=3; cycle_count=12.
- LDUR with mem_ready asserted 3 cycles into MEMORY -> mem_en high 3 cycles; wb_en follows the next cycle; instruction takes 7 cycles total.
- mem_write=1 with mem_ready held 0 and MEM_TIMEOUT=15 -> fault=1 after 15 MEMORY cycles; all enables 0; busy=0; counters frozen.
- run=0, step pulse from IDLE -> exactly one instruction retires; returns to IDLE; instr_count=1; a second step pulse issued mid-instruction is ignored.
- halt_req raised during EXECUTE of instruction 2 -> instruction 2 completes; halted=1 after its WRITEBACK; instr_count=2; a step from HALTED retires instruction 3 and returns to HALTED.
- Opcode 11'h7FF decoded -> HALTED after its WRITEBACK even with run=1; reset asserted mid-MEMORY clears all outputs within the same cycle.
